rocket_battery: RTL
===================

// Module: rocket_battery
// PURPOSE
//  N-channel rocket launcher controller; successor to the fixed 3-channel ammo-select/decimal-split block.
//  Keeps a per-channel ammo counter and takes a one-hot radar target select.
//  Fires on request, decrementing the selected channel; supports reload.
//  Drives a sequential BCD display of the selected channel's remaining ammo for the 7-seg driver.
// PARAMETERS
//  NUM_CH    3   number of launcher channels / radar inputs
//  AMMO_W    5   ammo counter width, bits
//  MAX_AMMO  20  per-channel load value at reset/reload; must be < 2**AMMO_W
//  DIGITS    2   BCD digits on the display output
// PORTS
//  clock       in   1               rising-edge clock
//  reset       in   1               synchronous, active-high
//  radar       in   NUM_CH          one-hot target select; bit i = channel i
//  fire        in   1               fire request, sampled each cycle
//  reload      in   1               reload all channels to MAX_AMMO
//  launched    out  1               1-cycle pulse: rocket launched
//  misfire     out  1               1-cycle pulse: fire rejected
//  target_ok   out  1               radar currently exactly one-hot
//  sel         out  clog2(NUM_CH)   latched selected channel index
//  empty       out  1               ammo[sel] == 0
//  bcd         out  4*DIGITS        BCD of ammo[sel]; digit 0 = units in [3:0]
//  bcd_valid   out  1               bcd matches the current ammo[sel]
//  overflow    out  1               ammo[sel] > 10**DIGITS-1; bcd saturated to all 9s
// BEHAVIOUR
//  Reset values:
//   - all ammo = MAX_AMMO; sel = 0.
//   - launched = misfire = 0; target_ok = 0.
//   - bcd = 0; bcd_valid = 0; overflow = 0; converter in IDLE.
//  Selection:
//   - target_ok = radar exactly one-hot (combinational).
//   - When target_ok, sel <= index of the set bit. Otherwise sel holds its value.
//  Fire/reload (registered, outputs visible the cycle after the request):
//   - reload=1: every ammo <= MAX_AMMO. No launched/misfire pulse, even if fire=1.
//     Reload has priority over fire.
//   - else fire=1 & target_ok & ammo[index]>0: ammo[index] decrements by 1; launched <= 1.
//     index = the current one-hot bit, not the stale sel.
//   - else fire=1: misfire <= 1; no counter change. Counters never wrap below 0.
//   - fire held high fires once per cycle while the conditions hold.
//  BCD converter FSM (sequential double-dabble):
//   - IDLE: if ammo[sel] != last converted value or sel changed -> LOAD; bcd_valid <= 0.
//   - LOAD: capture value into shift reg, clear BCD accumulator, iteration count = AMMO_W.
//   - SHIFT: one bit per cycle; add 3 to each digit >= 5 before the shift. After AMMO_W shifts -> DONE.
//   - DONE: bcd <= result (or all 9s with overflow=1 if out of range); bcd_valid <= 1; -> IDLE.
//   - Latency: value change to bcd_valid = AMMO_W+3 cycles.
//   - Source value changes during LOAD/SHIFT: abort, return to LOAD next cycle.
//     Old bcd is held with bcd_valid = 0.
//   - bcd and overflow change only in DONE or on reset.
//   - Accumulator is internally wide enough for AMMO_W bits; only DIGITS digits are output.
//  Reset mid-operation: all state returns to reset values; conversion restarts from IDLE the next cycle.
// TESTING
//  1. Release reset, radar=0 -> target_ok=0, sel=0; after AMMO_W+3 cycles bcd=0x20, bcd_valid=1.
//  2. radar=3'b010, 3 fire pulses -> 3 launched pulses; ammo[1]=17; bcd=0x17 after conversion; ammo[0], ammo[2] stay 20.
//  3. radar=3'b011, fire=1 -> misfire=1, launched=0, sel holds, all counters unchanged.
//  4. radar=3'b100, fire held 25 cycles -> 20 launched then 5 misfire; empty=1; bcd=0x00; no wrap to 31.
//  5. reload=1 & fire=1 same cycle -> all ammo=20, no launched/misfire; bcd returns to 0x20.
//  6. Fire during SHIFT, then reset mid-conversion -> bcd_valid drops, conversion restarts; after reset bcd=0, then 0x20.

Source files
------------

// File: rtl/rocket_battery.sv
// N-channel rocket launcher controller: per-channel ammo counters, one-hot radar select,
// fire/reload handling and a sequential double-dabble BCD display of the selected channel.
module rocket_battery #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned AMMO_W   = 5,
    parameter int unsigned MAX_AMMO = 20,
    parameter int unsigned DIGITS   = 2,
    localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   radar,
    input  logic                fire,
    input  logic                reload,
    output logic                launched,
    output logic                misfire,
    output logic                target_ok,
    output logic [SEL_W-1:0]    sel,
    output logic                empty,
    output logic [4*DIGITS-1:0] bcd,
    output logic                bcd_valid,
    output logic                overflow
);

    function automatic int unsigned num_digits(int unsigned bits);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << bits) - 64'd1;
        n = 0;
        do begin
            n++;
            v = v / 10;
        end while (v != 0);
        return n;
    endfunction

    localparam int unsigned ACC_DIGITS = num_digits(AMMO_W);
    localparam int unsigned ACC_W      = 4 * ACC_DIGITS;
    localparam int unsigned OUT_W      = 4 * DIGITS;
    localparam int unsigned EXT_W      = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int unsigned MAX_DISP   = 10 ** DIGITS - 1;
    localparam int unsigned CNT_W      = $clog2(AMMO_W + 1);
    localparam logic [AMMO_W-1:0] LOAD_VAL = AMMO_W'(MAX_AMMO);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} conv_state_e;

    logic [AMMO_W-1:0] ammo_q [NUM_CH];
    logic [SEL_W-1:0]  sel_q;
    logic              launched_q, misfire_q;
    logic [SEL_W-1:0]  radar_idx;
    logic [AMMO_W-1:0] cur_val;

    // Selection and fire/reload datapath
    always_comb begin
        radar_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (radar[i]) radar_idx = SEL_W'(i);
        end
    end

    assign target_ok = (radar != '0) && ((radar & (radar - NUM_CH'(1))) == '0);
    assign cur_val   = ammo_q[sel_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) ammo_q[i] <= LOAD_VAL;
            sel_q      <= '0;
            launched_q <= 1'b0;
            misfire_q  <= 1'b0;
        end else begin
            launched_q <= 1'b0;
            misfire_q  <= 1'b0;
            if (target_ok) sel_q <= radar_idx;
            if (reload) begin
                for (int i = 0; i < NUM_CH; i++) ammo_q[i] <= LOAD_VAL;
            end else if (fire) begin
                // Use the live one-hot index so a same-cycle retarget fires the new channel
                if (target_ok && (ammo_q[radar_idx] != '0)) begin
                    ammo_q[radar_idx] <= ammo_q[radar_idx] - AMMO_W'(1);
                    launched_q        <= 1'b1;
                end else begin
                    misfire_q <= 1'b1;
                end
            end
        end
    end

    // BCD converter
    conv_state_e       state_q, state_d;
    logic [AMMO_W-1:0] shreg_q, shreg_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AMMO_W-1:0] last_val_q, last_val_d;
    logic [SEL_W-1:0]  last_sel_q, last_sel_d;
    logic [OUT_W-1:0]  bcd_q, bcd_d;
    logic              bcd_valid_q, bcd_valid_d;
    logic              overflow_q, overflow_d;
    logic [EXT_W-1:0]  acc_ext;
    logic              changed;

    assign changed = (cur_val != last_val_q) || (sel_q != last_sel_q);
    assign acc_ext = EXT_W'(acc_q);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        last_val_d  = last_val_q;
        last_sel_d  = last_sel_q;
        bcd_d       = bcd_q;
        bcd_valid_d = bcd_valid_q;
        overflow_d  = overflow_q;
        acc_adj     = acc_q;
        unique case (state_q)
            StIdle: begin
                if (changed) begin
                    state_d     = StLoad;
                    bcd_valid_d = 1'b0;
                end
            end
            StLoad: begin
                shreg_d     = cur_val;
                acc_d       = '0;
                cnt_d       = CNT_W'(AMMO_W);
                last_val_d  = cur_val;
                last_sel_d  = sel_q;
                bcd_valid_d = 1'b0;
                state_d     = StShift;
            end
            StShift: begin
                if (changed) begin
                    state_d = StLoad;
                end else begin
                    for (int d = 0; d < ACC_DIGITS; d++) begin
                        if (acc_adj[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc_adj[4*d +: 4] + 4'd3;
                    end
                    acc_d   = {acc_adj[ACC_W-2:0], shreg_q[AMMO_W-1]};
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = StDone;
                end
            end
            StDone: begin
                if (32'(last_val_q) > MAX_DISP) begin
                    bcd_d      = {DIGITS{4'h9}};
                    overflow_d = 1'b1;
                end else begin
                    bcd_d      = acc_ext[OUT_W-1:0];
                    overflow_d = 1'b0;
                end
                bcd_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            last_val_q  <= '0;
            last_sel_q  <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            last_val_q  <= last_val_d;
            last_sel_q  <= last_sel_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign launched  = launched_q;
    assign misfire   = misfire_q;
    assign sel       = sel_q;
    assign empty     = (cur_val == '0);
    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign overflow  = overflow_q;

endmodule
